// File: rtl/regs_acc_pkg.sv
// Shared types for the register-file access controller: opcodes, FSM states, r0/r1 indices.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package regs_acc_pkg;

  typedef enum logic [2:0] {
    OP_NOP         = 3'd0,
    OP_RD          = 3'd1,
    OP_WR          = 3'd2,
    OP_MOV_TO_R0   = 3'd3,
    OP_MOV_FROM_R0 = 3'd4,
    OP_MOV_TO_R1   = 3'd5,
    OP_MOV_FROM_R1 = 3'd6,
    OP_RSVD        = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int unsigned R0_IDX = 0;
  localparam int unsigned R1_IDX = 1;

  // A move names r0/r1 implicitly, so two enabled ports would both target the same register.
  function automatic logic pmask_both(input logic [1:0] pmask);
    return pmask == 2'b11;
  endfunction

endpackage

// File: rtl/regs_acc_check.sv
// Combinational request validation: flags requests whose register-file outcome is ambiguous.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; evaluated every cycle, sampled by the controller on accept.
module regs_acc_check
  import regs_acc_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic [2:0]    i_op,
  input  logic [1:0]    i_pmask,
  input  logic [AW-1:0] i_sel0,
  input  logic [AW-1:0] i_sel1,
  output logic          o_err
);

  localparam logic [AW-1:0] R0_SEL = AW'(R0_IDX);
  localparam logic [AW-1:0] R1_SEL = AW'(R1_IDX);

  op_e  op;
  logic no_port;
  logic hit_r0;
  logic hit_r1;

  assign op      = op_e'(i_op);
  assign no_port = (i_pmask == 2'b00);
  // An enabled port selecting the move source would read and write the same register.
  assign hit_r0  = (i_pmask[0] && (i_sel0 == R0_SEL)) || (i_pmask[1] && (i_sel1 == R0_SEL));
  assign hit_r1  = (i_pmask[0] && (i_sel0 == R1_SEL)) || (i_pmask[1] && (i_sel1 == R1_SEL));

  // Decode the opcode into the error rules; NOP is always legal, reserved is always rejected.
  always_comb begin
    o_err = 1'b0;
    case (op)
      OP_NOP:         o_err = 1'b0;
      OP_RD:          o_err = no_port;
      OP_WR:          o_err = no_port || (pmask_both(i_pmask) && (i_sel0 == i_sel1));
      OP_MOV_TO_R0,
      OP_MOV_TO_R1:   o_err = no_port || pmask_both(i_pmask);
      OP_MOV_FROM_R0: o_err = no_port || pmask_both(i_pmask) || hit_r0;
      OP_MOV_FROM_R1: o_err = no_port || pmask_both(i_pmask) || hit_r1;
      default:        o_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/regs_access_ctrl.sv
// Register-file initiator: one request at a time, one-cycle strobes, one response per request.
// Latency: accept at edge N, strobes in cycle N+1, response valid from N+2 (3-cycle spacing).
// Backpressure: response held until i_rsp_ready; no new request accepted meanwhile. Option: REGS_ACC_STATS_EN.
module regs_access_ctrl
  import regs_acc_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_req_valid,
  output logic          o_req_ready,
  input  logic [2:0]    i_req_op,
  input  logic [1:0]    i_req_pmask,
  input  logic [AW-1:0] i_req_sel0,
  input  logic [AW-1:0] i_req_sel1,
  input  logic [DW-1:0] i_req_wdata0,
  input  logic [DW-1:0] i_req_wdata1,
  output logic          o_rsp_valid,
  input  logic          i_rsp_ready,
  output logic [DW-1:0] o_rsp_rdata0,
  output logic [DW-1:0] o_rsp_rdata1,
  output logic          o_rsp_err,
  output logic [AW-1:0] o_reg_sel0,
  output logic [AW-1:0] o_reg_sel1,
  output logic          o_reg_read0,
  output logic          o_reg_read1,
  output logic          o_reg_write0,
  output logic          o_reg_write1,
  output logic [DW-1:0] o_reg_wdata0,
  output logic [DW-1:0] o_reg_wdata1,
  input  logic [DW-1:0] i_reg_rdata0,
  input  logic [DW-1:0] i_reg_rdata1,
  output logic [1:0]    o_mov_to_r0,
  output logic [1:0]    o_mov_from_r0,
  output logic [1:0]    o_mov_to_r1,
  output logic [1:0]    o_mov_from_r1
`ifdef REGS_ACC_STATS_EN
  ,
  output logic [31:0]   o_stat_ops,
  output logic [31:0]   o_stat_errs
`endif
);

  state_e        state_q,       state_d;
  logic          req_ready_q,   req_ready_d;
  logic          err_q,         err_d;
  logic [AW-1:0] sel0_q,        sel0_d;
  logic [AW-1:0] sel1_q,        sel1_d;
  logic [DW-1:0] wdata0_q,      wdata0_d;
  logic [DW-1:0] wdata1_q,      wdata1_d;
  logic [1:0]    read_q,        read_d;
  logic [1:0]    write_q,       write_d;
  logic [1:0]    mov_to_r0_q,   mov_to_r0_d;
  logic [1:0]    mov_from_r0_q, mov_from_r0_d;
  logic [1:0]    mov_to_r1_q,   mov_to_r1_d;
  logic [1:0]    mov_from_r1_q, mov_from_r1_d;
  logic          rsp_valid_q,   rsp_valid_d;
  logic          rsp_err_q,     rsp_err_d;
  logic [DW-1:0] rdata0_q,      rdata0_d;
  logic [DW-1:0] rdata1_q,      rdata1_d;

  logic          chk_err;
  logic          accept;

  regs_acc_check #(.AW(AW)) u_check (
    .i_op    (i_req_op),
    .i_pmask (i_req_pmask),
    .i_sel0  (i_req_sel0),
    .i_sel1  (i_req_sel1),
    .o_err   (chk_err)
  );

  assign accept = (state_q == ST_IDLE) && i_req_valid && req_ready_q;

  // Next-state and next-output logic; strobes are computed at accept so they are registered during EXEC.
  always_comb begin
    state_d       = state_q;
    err_d         = err_q;
    sel0_d        = sel0_q;
    sel1_d        = sel1_q;
    wdata0_d      = wdata0_q;
    wdata1_d      = wdata1_q;
    read_d        = 2'b00;
    write_d       = 2'b00;
    mov_to_r0_d   = 2'b00;
    mov_from_r0_d = 2'b00;
    mov_to_r1_d   = 2'b00;
    mov_from_r1_d = 2'b00;
    rsp_err_d     = rsp_err_q;
    rdata0_d      = rdata0_q;
    rdata1_d      = rdata1_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d  = ST_EXEC;
          err_d    = chk_err;
          sel0_d   = i_req_sel0;
          sel1_d   = i_req_sel1;
          wdata0_d = i_req_wdata0;
          wdata1_d = i_req_wdata1;
          if (!chk_err) begin
            case (op_e'(i_req_op))
              OP_RD:          read_d        = i_req_pmask;
              OP_WR:          write_d       = i_req_pmask;
              OP_MOV_TO_R0:   mov_to_r0_d   = i_req_pmask;
              OP_MOV_FROM_R0: mov_from_r0_d = i_req_pmask;
              OP_MOV_TO_R1:   mov_to_r1_d   = i_req_pmask;
              OP_MOV_FROM_R1: mov_from_r1_d = i_req_pmask;
              default:        ;
            endcase
          end
        end
      end
      ST_EXEC: begin
        // Read strobes are only ever set for a legal RD, so they also gate the capture.
        state_d   = ST_RESP;
        rsp_err_d = err_q;
        rdata0_d  = read_q[0] ? i_reg_rdata0 : '0;
        rdata1_d  = read_q[1] ? i_reg_rdata1 : '0;
      end
      ST_RESP: begin
        if (i_rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    req_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
  end

  // State and output registers; async reset clears strobes immediately and drops any in-flight work.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= ST_IDLE;
      req_ready_q   <= 1'b0;
      err_q         <= 1'b0;
      sel0_q        <= '0;
      sel1_q        <= '0;
      wdata0_q      <= '0;
      wdata1_q      <= '0;
      read_q        <= 2'b00;
      write_q       <= 2'b00;
      mov_to_r0_q   <= 2'b00;
      mov_from_r0_q <= 2'b00;
      mov_to_r1_q   <= 2'b00;
      mov_from_r1_q <= 2'b00;
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rdata0_q      <= '0;
      rdata1_q      <= '0;
    end else begin
      state_q       <= state_d;
      req_ready_q   <= req_ready_d;
      err_q         <= err_d;
      sel0_q        <= sel0_d;
      sel1_q        <= sel1_d;
      wdata0_q      <= wdata0_d;
      wdata1_q      <= wdata1_d;
      read_q        <= read_d;
      write_q       <= write_d;
      mov_to_r0_q   <= mov_to_r0_d;
      mov_from_r0_q <= mov_from_r0_d;
      mov_to_r1_q   <= mov_to_r1_d;
      mov_from_r1_q <= mov_from_r1_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_err_q     <= rsp_err_d;
      rdata0_q      <= rdata0_d;
      rdata1_q      <= rdata1_d;
    end
  end

  assign o_req_ready   = req_ready_q;
  assign o_rsp_valid   = rsp_valid_q;
  assign o_rsp_err     = rsp_err_q;
  assign o_rsp_rdata0  = rdata0_q;
  assign o_rsp_rdata1  = rdata1_q;
  assign o_reg_sel0    = sel0_q;
  assign o_reg_sel1    = sel1_q;
  assign o_reg_wdata0  = wdata0_q;
  assign o_reg_wdata1  = wdata1_q;
  assign o_reg_read0   = read_q[0];
  assign o_reg_read1   = read_q[1];
  assign o_reg_write0  = write_q[0];
  assign o_reg_write1  = write_q[1];
  assign o_mov_to_r0   = mov_to_r0_q;
  assign o_mov_from_r0 = mov_from_r0_q;
  assign o_mov_to_r1   = mov_to_r1_q;
  assign o_mov_from_r1 = mov_from_r1_q;

`ifdef REGS_ACC_STATS_EN
  logic [31:0] stat_ops_q,  stat_ops_d;
  logic [31:0] stat_errs_q, stat_errs_d;
  logic        rsp_hs;

  assign rsp_hs = rsp_valid_q && i_rsp_ready;

  // Count completed responses and rejected ones; both wrap naturally at 2**32.
  always_comb begin
    stat_ops_d  = stat_ops_q;
    stat_errs_d = stat_errs_q;
    if (rsp_hs) begin
      stat_ops_d = stat_ops_q + 32'd1;
      if (rsp_err_q) stat_errs_d = stat_errs_q + 32'd1;
    end
  end

  // Statistics counter registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      stat_ops_q  <= '0;
      stat_errs_q <= '0;
    end else begin
      stat_ops_q  <= stat_ops_d;
      stat_errs_q <= stat_errs_d;
    end
  end

  assign o_stat_ops  = stat_ops_q;
  assign o_stat_errs = stat_errs_q;
`endif

endmodule

// File: tb/tb_regs_access_ctrl.sv
// Directed bench for regs_access_ctrl: vector table plus backpressure and mid-EXEC reset sequences.
// Latency: checks strobes at N+1 and response at N+2 after the accept edge N.
// Backpressure: holds i_rsp_ready low in one sequence to verify response stability.
module tb_regs_access_ctrl;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_req_valid = 1'b0;
  logic          o_req_ready;
  logic [2:0]    i_req_op = '0;
  logic [1:0]    i_req_pmask = '0;
  logic [AW-1:0] i_req_sel0 = '0;
  logic [AW-1:0] i_req_sel1 = '0;
  logic [DW-1:0] i_req_wdata0 = '0;
  logic [DW-1:0] i_req_wdata1 = '0;
  logic          o_rsp_valid;
  logic          i_rsp_ready = 1'b1;
  logic [DW-1:0] o_rsp_rdata0;
  logic [DW-1:0] o_rsp_rdata1;
  logic          o_rsp_err;
  logic [AW-1:0] o_reg_sel0;
  logic [AW-1:0] o_reg_sel1;
  logic          o_reg_read0;
  logic          o_reg_read1;
  logic          o_reg_write0;
  logic          o_reg_write1;
  logic [DW-1:0] o_reg_wdata0;
  logic [DW-1:0] o_reg_wdata1;
  logic [DW-1:0] i_reg_rdata0;
  logic [DW-1:0] i_reg_rdata1;
  logic [1:0]    o_mov_to_r0;
  logic [1:0]    o_mov_from_r0;
  logic [1:0]    o_mov_to_r1;
  logic [1:0]    o_mov_from_r1;

  logic [DW-1:0] regs [32];

  int checks   = 0;
  int failures = 0;

  always #5 i_clk = ~i_clk;

  // Simple register file model: combinational read from select.
  assign i_reg_rdata0 = regs[o_reg_sel0];
  assign i_reg_rdata1 = regs[o_reg_sel1];

  regs_access_ctrl #(.DW(DW), .AW(AW)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_req_valid   (i_req_valid),
    .o_req_ready   (o_req_ready),
    .i_req_op      (i_req_op),
    .i_req_pmask   (i_req_pmask),
    .i_req_sel0    (i_req_sel0),
    .i_req_sel1    (i_req_sel1),
    .i_req_wdata0  (i_req_wdata0),
    .i_req_wdata1  (i_req_wdata1),
    .o_rsp_valid   (o_rsp_valid),
    .i_rsp_ready   (i_rsp_ready),
    .o_rsp_rdata0  (o_rsp_rdata0),
    .o_rsp_rdata1  (o_rsp_rdata1),
    .o_rsp_err     (o_rsp_err),
    .o_reg_sel0    (o_reg_sel0),
    .o_reg_sel1    (o_reg_sel1),
    .o_reg_read0   (o_reg_read0),
    .o_reg_read1   (o_reg_read1),
    .o_reg_write0  (o_reg_write0),
    .o_reg_write1  (o_reg_write1),
    .o_reg_wdata0  (o_reg_wdata0),
    .o_reg_wdata1  (o_reg_wdata1),
    .i_reg_rdata0  (i_reg_rdata0),
    .i_reg_rdata1  (i_reg_rdata1),
    .o_mov_to_r0   (o_mov_to_r0),
    .o_mov_from_r0 (o_mov_from_r0),
    .o_mov_to_r1   (o_mov_to_r1),
    .o_mov_from_r1 (o_mov_from_r1)
  );

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  pm;
    logic [4:0]  s0;
    logic [4:0]  s1;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [11:0] strb;
    logic        err;
    logic [31:0] rd0;
    logic [31:0] rd1;
  } vec_t;

  vec_t vec [16];

  // Strobe packing: {read, write, mov_to_r0, mov_from_r0, mov_to_r1, mov_from_r1}, each [1:0].
  function automatic logic [11:0] mk(input logic [1:0] rd, input logic [1:0] wr,
                                     input logic [1:0] mt0, input logic [1:0] mf0,
                                     input logic [1:0] mt1, input logic [1:0] mf1);
    return {rd, wr, mt0, mf0, mt1, mf1};
  endfunction

  function automatic logic [11:0] strobes();
    return {o_reg_read1, o_reg_read0, o_reg_write1, o_reg_write0,
            o_mov_to_r0, o_mov_from_r0, o_mov_to_r1, o_mov_from_r1};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Bounded wait for request ready, sampled away from the clock edge.
  task automatic wait_ready(input string name);
    int n = 0;
    while (o_req_ready !== 1'b1 && n < 20) begin
      @(posedge i_clk); #1;
      n++;
    end
    chk({name, "_ready_timeout"}, {63'd0, o_req_ready}, 64'd1);
  endtask

  task automatic drive(input vec_t v);
    i_req_op     = v.op;
    i_req_pmask  = v.pm;
    i_req_sel0   = v.s0;
    i_req_sel1   = v.s1;
    i_req_wdata0 = v.w0;
    i_req_wdata1 = v.w1;
    i_req_valid  = 1'b1;
  endtask

  initial begin
    vec_t v;
    logic [31:0] hold0, hold1;

    for (int i = 0; i < 32; i++) regs[i] = 32'hA000_0000 | i;
    regs[4] = 32'h11;
    regs[9] = 32'h22;
    regs[6] = 32'h66;

    //           op  pm  s0  s1  w0            w1            strobes                                       err rd0     rd1
    vec[0]  = '{3'd1, 2'd3, 5'd4,  5'd9,  32'h0,        32'h0,        mk(2'b11,2'b00,2'b00,2'b00,2'b00,2'b00), 1'b0, 32'h11, 32'h22};
    vec[1]  = '{3'd2, 2'd1, 5'd7,  5'd0,  32'hDEADBEEF, 32'h0,        mk(2'b00,2'b01,2'b00,2'b00,2'b00,2'b00), 1'b0, 32'h0,  32'h0};
    vec[2]  = '{3'd2, 2'd3, 5'd5,  5'd5,  32'h1,        32'h2,        mk(2'b00,2'b00,2'b00,2'b00,2'b00,2'b00), 1'b1, 32'h0,  32'h0};
    vec[3]  = '{3'd5, 2'd2, 5'd0,  5'd12, 32'h0,        32'h0,        mk(2'b00,2'b00,2'b00,2'b00,2'b10,2'b00), 1'b0, 32'h0,  32'h0};
    vec[4]  = '{3'd4, 2'd1, 5'd0,  5'd3,  32'h0,        32'h0,        mk(2'b00,2'b00,2'b00,2'b00,2'b00,2'b00), 1'b1, 32'h0,  32'h0};
    vec[5]  = '{3'd0, 2'd0, 5'd2,  5'd3,  32'h0,        32'h0,        mk(2'b00,2'b00,2'b00,2'b00,2'b00,2'b00), 1'b0, 32'h0,  32'h0};
    vec[6]  = '{3'd7, 2'd1, 5'd2,  5'd3,  32'h0,        32'h0,        mk(2'b00,2'b00,2'b00,2'b00,2'b00,2'b00), 1'b1, 32'h0,  32'h0};
    vec[7]  = '{3'd1, 2'd0, 5'd4,  5'd9,  32'h0,        32'h0,        mk(2'b00,2'b00,2'b00,2'b00,2'b00,2'b00), 1'b1, 32'h0,  32'h0};
    vec[8]  = '{3'd3, 2'd3, 5'd8,  5'd9,  32'h0,        32'h0,        mk(2'b00,2'b00,2'b00,2'b00,2'b00,2'b00), 1'b1, 32'h0,  32'h0};
    vec[9]  = '{3'd1, 2'd3, 5'd6,  5'd6,  32'h0,        32'h0,        mk(2'b11,2'b00,2'b00,2'b00,2'b00,2'b00), 1'b0, 32'h66, 32'h66};
    vec[10] = '{3'd1, 2'd1, 5'd4,  5'd9,  32'h0,        32'h0,        mk(2'b01,2'b00,2'b00,2'b00,2'b00,2'b00), 1'b0, 32'h11, 32'h0};
    vec[11] = '{3'd6, 2'd2, 5'd5,  5'd1,  32'h0,        32'h0,        mk(2'b00,2'b00,2'b00,2'b00,2'b00,2'b00), 1'b1, 32'h0,  32'h0};
    vec[12] = '{3'd6, 2'd2, 5'd5,  5'd0,  32'h0,        32'h0,        mk(2'b00,2'b00,2'b00,2'b00,2'b00,2'b10), 1'b0, 32'h0,  32'h0};
    vec[13] = '{3'd4, 2'd2, 5'd0,  5'd3,  32'h0,        32'h0,        mk(2'b00,2'b00,2'b00,2'b10,2'b00,2'b00), 1'b0, 32'h0,  32'h0};
    vec[14] = '{3'd2, 2'd3, 5'd2,  5'd3,  32'h12345678, 32'h9ABCDEF0, mk(2'b00,2'b11,2'b00,2'b00,2'b00,2'b00), 1'b0, 32'h0,  32'h0};
    vec[15] = '{3'd3, 2'd1, 5'd8,  5'd0,  32'h0,        32'h0,        mk(2'b00,2'b00,2'b01,2'b00,2'b00,2'b00), 1'b0, 32'h0,  32'h0};

    // Reset state.
    #2;
    chk("rst_ready",   {63'd0, o_req_ready}, 64'd0);
    chk("rst_valid",   {63'd0, o_rsp_valid}, 64'd0);
    chk("rst_err",     {63'd0, o_rsp_err},   64'd0);
    chk("rst_strobes", {52'd0, strobes()},   64'd0);
    chk("rst_rdata",   {o_rsp_rdata1, o_rsp_rdata0}, 64'd0);
    chk("rst_selwd",   {22'd0, o_reg_sel1, o_reg_sel0, o_reg_wdata0}, 64'd0);
    @(posedge i_clk); @(negedge i_clk);
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    chk("post_rst_ready", {63'd0, o_req_ready}, 64'd1);

    // Table-driven vectors with the response consumed immediately.
    for (int i = 0; i < 16; i++) begin
      v = vec[i];
      wait_ready($sformatf("v%0d", i));
      @(negedge i_clk);
      drive(v);
      @(posedge i_clk); #1;
      i_req_valid = 1'b0;
      chk($sformatf("v%0d_strobes", i), {52'd0, strobes()}, {52'd0, v.strb});
      chk($sformatf("v%0d_sel", i), {54'd0, o_reg_sel1, o_reg_sel0}, {54'd0, v.s1, v.s0});
      chk($sformatf("v%0d_wdata", i), {o_reg_wdata1, o_reg_wdata0}, {v.w1, v.w0});
      chk($sformatf("v%0d_exec_ready", i), {62'd0, o_req_ready, o_rsp_valid}, 64'd0);
      @(posedge i_clk); #1;
      chk($sformatf("v%0d_strobes_off", i), {52'd0, strobes()}, 64'd0);
      chk($sformatf("v%0d_rsp", i), {62'd0, o_rsp_valid, o_rsp_err}, {62'd0, 1'b1, v.err});
      chk($sformatf("v%0d_rdata", i), {o_rsp_rdata1, o_rsp_rdata0}, {v.rd1, v.rd0});
      @(posedge i_clk); #1;
      chk($sformatf("v%0d_after_hs", i), {62'd0, o_rsp_valid, o_req_ready}, 64'd1);
    end

    // Backpressure: response held 5 cycles while a second request waits.
    i_rsp_ready = 1'b0;
    @(negedge i_clk);
    drive(vec[0]);
    @(posedge i_clk); #1;
    chk("bp_strobes", {52'd0, strobes()}, {52'd0, vec[0].strb});
    v = vec[1];
    drive(v);
    @(posedge i_clk); #1;
    hold0 = 32'h11;
    hold1 = 32'h22;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp_hold%0d_ctl", c), {60'd0, o_rsp_valid, o_rsp_err, o_req_ready, |strobes()}, 64'h8);
      chk($sformatf("bp_hold%0d_data", c), {o_rsp_rdata1, o_rsp_rdata0}, {hold1, hold0});
      @(posedge i_clk); #1;
    end
    @(negedge i_clk);
    i_rsp_ready = 1'b1;
    @(posedge i_clk); #1;
    chk("bp_hs", {61'd0, o_rsp_valid, o_req_ready, |strobes()}, 64'h2);
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    chk("bp_next_strobes", {52'd0, strobes()}, {52'd0, v.strb});
    chk("bp_next_sel", {59'd0, o_reg_sel0}, {59'd0, v.s0});
    @(posedge i_clk); #1;
    chk("bp_next_rsp", {62'd0, o_rsp_valid, o_rsp_err}, 64'h2);
    @(posedge i_clk); #1;

    // Reset during EXEC of a write.
    wait_ready("rstx");
    @(negedge i_clk);
    drive(vec[1]);
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    chk("rstx_write_on", {63'd0, o_reg_write0}, 64'd1);
    i_rst = 1'b1;
    #1;
    chk("rstx_write_drop", {52'd0, strobes()}, 64'd0);
    chk("rstx_ready_low", {62'd0, o_req_ready, o_rsp_valid}, 64'd0);
    @(posedge i_clk); @(negedge i_clk);
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    chk("rstx_ready_back", {62'd0, o_req_ready, o_rsp_valid}, 64'h2);
    for (int c = 0; c < 3; c++) begin
      @(posedge i_clk); #1;
      chk($sformatf("rstx_no_rsp%0d", c), {62'd0, o_rsp_valid, |strobes()}, 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regs_access_ctrl.md
Name: regs_access_ctrl

Overview:
- Initiator for the two-port register file.
- Takes one register-access request at a time from the issue stage over a valid/ready handshake.
- Drives the register file's select, read, write and move strobes for exactly one cycle, captures read data, and returns one response per request.
- Rejects requests whose outcome in the register file would be ambiguous.

Parameters:
- DW, 32, register data width
- AW, 5, register select width (2**AW registers)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous, active-high reset
- i_req_valid  in  1  request valid
- o_req_ready  out  1  request accepted when valid&ready
- i_req_op  in  3  opcode: 0 NOP, 1 RD, 2 WR, 3 MOV_TO_R0, 4 MOV_FROM_R0, 5 MOV_TO_R1, 6 MOV_FROM_R1; 7 reserved
- i_req_pmask  in  2  port enables: bit0 = port 0, bit1 = port 1
- i_req_sel0  in  AW  port 0 register select
- i_req_sel1  in  AW  port 1 register select
- i_req_wdata0  in  DW  port 0 write data
- i_req_wdata1  in  DW  port 1 write data
- o_rsp_valid  out  1  response valid
- i_rsp_ready  in  1  response consumed when valid&ready
- o_rsp_rdata0  out  DW  port 0 read data
- o_rsp_rdata1  out  DW  port 1 read data
- o_rsp_err  out  1  request rejected; no strobes issued
- o_reg_sel0  out  AW  register file select, port 0
- o_reg_sel1  out  AW  register file select, port 1
- o_reg_read0  out  1  read strobe, port 0
- o_reg_read1  out  1  read strobe, port 1
- o_reg_write0  out  1  write strobe, port 0
- o_reg_write1  out  1  write strobe, port 1
- o_reg_wdata0  out  DW  write data, port 0
- o_reg_wdata1  out  DW  write data, port 1
- i_reg_rdata0  in  DW  read data, port 0 (combinational from sel)
- i_reg_rdata1  in  DW  read data, port 1 (combinational from sel)
- o_mov_to_r0  out  2  move sel[p] into r0, p = port
- o_mov_from_r0  out  2  move r0 into sel[p]
- o_mov_to_r1  out  2  move sel[p] into r1
- o_mov_from_r1  out  2  move r1 into sel[p]

Behaviour:
- Reset (async, i_rst high): state IDLE. o_req_ready=0 while reset is high, 1 in IDLE after reset. All strobes, o_rsp_valid, o_rsp_err, rdata, sel, wdata = 0.
- Reset mid-operation: strobes drop immediately. The in-flight request and any pending response are discarded.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - o_req_ready=1.
  - On valid&ready, register op, pmask, sels and wdata; go to EXEC.
- EXEC (exactly one cycle):
  - o_req_ready=0. Sel/wdata are driven from the registered request.
  - Valid RD: o_reg_read[p]=pmask[p]. i_reg_rdata[p] is captured into o_rsp_rdata[p] at the end of EXEC; the disabled port captures 0.
  - Valid WR: o_reg_write[p]=pmask[p].
  - Valid MOV_*: only the matching vector's bit p = pmask[p].
  - Invalid request or NOP: no strobes. The error flag is latched for the response.
  - Next state: RESP.
- RESP:
  - o_rsp_valid=1; data and err are held stable until i_rsp_ready.
  - On handshake, go to IDLE. o_req_ready returns to 1 the following cycle.
- Latency: accept edge N, strobes during cycle N+1, o_rsp_valid from cycle N+2. Minimum request-to-request spacing is 3 cycles.
- Outside EXEC, all strobes are 0. Sel/wdata hold their last values (don't-care to the register file).
- Error rules (err=1, rdata=0, no strobes):
  - op 7;
  - non-NOP with pmask=0;
  - any MOV_* with pmask=3 (both ports would target r0/r1);
  - WR with pmask=3 and sel0==sel1;
  - MOV_FROM_R0/R1 where an enabled sel equals the source register (0 or 1 respectively).
- Not errors:
  - RD with pmask=3 and sel0==sel1: legal, both rdata equal.
  - NOP: err=0, rdata=0.

Optional Feature:
- Macro: REGS_ACC_STATS_EN.
- With the macro: add ports o_stat_ops (out, 32) and o_stat_errs (out, 32).
  - o_stat_ops increments on each response handshake.
  - o_stat_errs increments on each response handshake with err=1.
  - Both counters wrap at 2**32 and reset to 0.
- Without the macro: the ports do not exist and no counter logic is present.

Decomposition:
- Package regs_acc_pkg:
  - op enum (the seven opcodes plus reserved);
  - FSM state enum;
  - localparams for the r0/r1 indices (0, 1).
- Sub-module regs_acc_check: combinational validation (op, pmask, sels → err). Instantiated once and latched on accept.

Test Plan:
- RD pmask=3, sel0=4, sel1=9, regfile r4=0x11, r9=0x22 → read0/read1 high only in N+1; response rdata0=0x11, rdata1=0x22, err=0 at N+2.
- WR pmask=1, sel0=7, wdata0=0xDEADBEEF → only write0 pulses for 1 cycle with sel0=7; response err=0, rdata=0.
- WR pmask=3, sel0=sel1=5 → no strobes at all; err=1.
- MOV_TO_R1 pmask=2, sel1=12 → o_mov_to_r1=2'b10 for 1 cycle; MOV_FROM_R0 pmask=1, sel0=0 → err=1, no strobe.
- Hold i_rsp_ready=0 for 5 cycles after an RD → o_rsp_valid and data stable throughout, o_req_ready=0; accepted next request is strobed only after the handshake.
- Assert i_rst during EXEC of a WR → write strobe drops immediately, no response after reset release, o_req_ready=1 one cycle after release.
